// File: rtl/aba_output_buffer_pkg.sv
// Shared types and constants for the ABA result path and its output buffer.
// The packed result layout (overflow flag above the data word) is reused by the buffer storage.
package aba_output_buffer_pkg;

  localparam int DATA_W            = 64;
  localparam int DEFAULT_OUT_DEPTH = 8;
  localparam int DEFAULT_ADDR_W    = 10;

  typedef struct packed {
    logic              ovf;
    logic [DATA_W-1:0] data;
  } aba_result_t;

endpackage

// File: rtl/aba_output_buffer_sync_fifo_ctrl.sv
// Pointer, occupancy and push/pop qualification for a single-clock FIFO.
// clear wins over push and pop; pointers wrap naturally because DEPTH is a power of two.
module sync_fifo_ctrl #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             push,
  output logic             pop,
  output logic             drop,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  always_comb begin
    empty = (count == '0);
    full  = (count == CNT_W'(DEPTH));
    pop   = !empty && out_ready && !clear;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    push  = in_valid && !clear && (!full || pop);
    drop  = in_valid && !clear && full && !pop;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aba_output_buffer.sv
// Buffers valid-only ABA results and hands them to the SRAM/bus writer over valid/ready.
// Each word carries its overflow flag and a sequential write address; sticky flags record drops and overflows.
module aba_output_buffer
  import aba_output_buffer_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_OUT_DEPTH,
  parameter int DATA_W = aba_output_buffer_pkg::DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_overflow,
  output logic [ADDR_W-1:0] out_addr,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              drop_err,
  output logic              ovf_seen
);

  // Same layout as aba_result_t, but sized by this instance's DATA_W.
  typedef struct packed {
    logic              ovf;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic             push;
  logic             pop;
  logic             drop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  entry_t           mem [DEPTH];

  sync_fifo_ctrl #(
    .DEPTH(DEPTH)
  ) u_ctrl (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (clear),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .push     (push),
    .pop      (pop),
    .drop     (drop),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Storage is reset so the show-ahead head reads zero out of reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{ovf: in_overflow, data: in_data};
    end
  end

  always_comb begin
    out_valid    = !empty;
    out_data     = mem[rd_ptr].data;
    out_overflow = mem[rd_ptr].ovf;
  end

  // Address tracks the head entry: it advances only when a word leaves.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     out_addr <= '0;
    else if (clear) out_addr <= base_addr;
    else if (pop)   out_addr <= out_addr + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      drop_err <= 1'b0;
      ovf_seen <= 1'b0;
    end else if (clear) begin
      drop_err <= 1'b0;
      ovf_seen <= 1'b0;
    end else begin
      if (drop)                drop_err <= 1'b1;
      if (push && in_overflow) ovf_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aba_output_buffer.sv
// Self-checking bench for aba_output_buffer: scoreboard of {ovf,data} plus a model address counter.
module tb_aba_output_buffer;

  localparam int DEPTH = 8;
  localparam int DW    = 64;
  localparam int AW    = 10;
  localparam int W     = DW + 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          n_rst;
  logic          clear;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_overflow;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_overflow;
  logic [AW-1:0] out_addr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          drop_err;
  logic          ovf_seen;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_addr;

  aba_output_buffer #(
    .DEPTH (DEPTH),
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (clear),
    .base_addr   (base_addr),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_overflow (in_overflow),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_overflow(out_overflow),
    .out_addr    (out_addr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .drop_err    (drop_err),
    .ovf_seen    (ovf_seen)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: model and scoreboard at the falling edge, then advance past the rising edge.
  task automatic tick();
    logic         pop_m;
    logic         push_m;
    logic [W-1:0] head;
    @(negedge clk);
    if (n_rst) begin
      pop_m  = (exp_q.size() != 0) && out_ready && !clear;
      push_m = in_valid && !clear && ((exp_q.size() < DEPTH) || pop_m);
      n_cmp++;
      if (out_valid !== (exp_q.size() != 0)) begin
        n_err++;
        $display("FAIL sb_valid: got %b exp %b", out_valid, exp_q.size() != 0);
      end
      if (pop_m) begin
        head = exp_q.pop_front();
        n_cmp++;
        if ({out_overflow, out_data} !== head || out_addr !== exp_addr) begin
          n_err++;
          $display("FAIL sb_head: got ovf=%b data=%h addr=%h exp ovf=%b data=%h addr=%h",
                   out_overflow, out_data, out_addr, head[DW], head[DW-1:0], exp_addr);
        end
        exp_addr = exp_addr + 1'b1;
      end
      if (clear) begin
        exp_q.delete();
        exp_addr = base_addr;
      end
      if (push_m) exp_q.push_back({in_overflow, in_data});
    end
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic push_word(input logic [DW-1:0] d, input logic o);
    in_valid    = 1'b1;
    in_data     = d;
    in_overflow = o;
    tick();
    in_valid    = 1'b0;
    in_data     = {$urandom, $urandom};
    in_overflow = 1'($urandom_range(0, 1));
  endtask

  task automatic do_clear(input logic [AW-1:0] b);
    clear     = 1'b1;
    base_addr = b;
    tick();
    clear     = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 2 && exp_q.size() != 0; i++) tick();
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (empty !== 1'b1 || count !== '0) begin
      n_err++;
      $display("FAIL drain_empty: got empty=%b count=%0d exp empty=1 count=0", empty, count);
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (count !== '0)       begin n_err++; $display("FAIL reset_count: got %0d exp 0", count); end
    n_cmp++; if (empty !== 1'b1)     begin n_err++; $display("FAIL reset_empty: got %b exp 1", empty); end
    n_cmp++; if (full !== 1'b0)      begin n_err++; $display("FAIL reset_full: got %b exp 0", full); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    n_cmp++; if (out_data !== '0)    begin n_err++; $display("FAIL reset_data: got %h exp 0", out_data); end
    n_cmp++; if (out_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b exp 0", out_overflow); end
    n_cmp++; if (out_addr !== '0)    begin n_err++; $display("FAIL reset_addr: got %h exp 0", out_addr); end
    n_cmp++; if (drop_err !== 1'b0)  begin n_err++; $display("FAIL reset_drop: got %b exp 0", drop_err); end
    n_cmp++; if (ovf_seen !== 1'b0)  begin n_err++; $display("FAIL reset_ovf_seen: got %b exp 0", ovf_seen); end
  endtask

  task automatic test_in_order();
    push_word(64'h11, 1'b0);
    push_word(64'h22, 1'b0);
    push_word(64'h33, 1'b0);
    n_cmp++; if (count !== CW'(3)) begin n_err++; $display("FAIL order_count: got %0d exp 3", count); end
    n_cmp++; if (out_data !== 64'h11) begin n_err++; $display("FAIL order_head: got %h exp 11", out_data); end
    n_cmp++; if (out_addr !== '0) begin n_err++; $display("FAIL order_addr: got %h exp 0", out_addr); end
    drain();
  endtask

  task automatic test_addr_wrap();
    do_clear(10'h3FE);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word({$urandom, $urandom}, 1'b0);
    drain();
    n_cmp++; if (out_addr !== 10'h002) begin n_err++; $display("FAIL wrap_addr: got %h exp 002", out_addr); end
  endtask

  task automatic test_full_drop();
    logic [DW-1:0] first;
    do_clear('0);
    first = {$urandom, $urandom};
    push_word(first, 1'b0);
    for (int i = 1; i < DEPTH; i++) push_word({$urandom, $urandom}, 1'b0);
    push_word(64'h99, 1'b0);
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b exp 1", full); end
    n_cmp++; if (count !== CW'(DEPTH)) begin n_err++; $display("FAIL full_count: got %0d exp %0d", count, DEPTH); end
    n_cmp++; if (drop_err !== 1'b1) begin n_err++; $display("FAIL full_drop: got %b exp 1", drop_err); end
    n_cmp++; if (out_data !== first) begin n_err++; $display("FAIL full_head: got %h exp %h", out_data, first); end
    in_valid = 1'b1; in_data = 64'hAB; in_overflow = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (count !== CW'(DEPTH)) begin n_err++; $display("FAIL full_pp_count: got %0d exp %0d", count, DEPTH); end
    n_cmp++; if (drop_err !== 1'b1) begin n_err++; $display("FAIL full_pp_drop: got %b exp 1", drop_err); end
    drain();
  endtask

  task automatic test_overflow();
    do_clear('0);
    push_word(64'h44, 1'b1);
    n_cmp++; if (out_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_head: got %b exp 1", out_overflow); end
    n_cmp++; if (ovf_seen !== 1'b1) begin n_err++; $display("FAIL ovf_seen: got %b exp 1", ovf_seen); end
    drain();
    n_cmp++; if (ovf_seen !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b exp 1", ovf_seen); end
    do_clear('0);
    n_cmp++; if (ovf_seen !== 1'b0) begin n_err++; $display("FAIL ovf_cleared: got %b exp 0", ovf_seen); end
  endtask

  task automatic test_clear_priority();
    do_clear('0);
    for (int i = 0; i < DEPTH + 1; i++) push_word({$urandom, $urandom}, 1'b0);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    n_cmp++; if (count !== CW'(5) || drop_err !== 1'b1) begin
      n_err++; $display("FAIL clr_setup: got count=%0d drop=%b exp count=5 drop=1", count, drop_err);
    end
    clear = 1'b1; base_addr = 10'h155; in_valid = 1'b1; in_data = 64'h77; out_ready = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (count !== '0 || empty !== 1'b1) begin
      n_err++; $display("FAIL clr_count: got count=%0d empty=%b exp 0/1", count, empty);
    end
    n_cmp++; if (drop_err !== 1'b0) begin n_err++; $display("FAIL clr_drop: got %b exp 0", drop_err); end
    n_cmp++; if (out_addr !== 10'h155) begin n_err++; $display("FAIL clr_addr: got %h exp 155", out_addr); end
    push_word(64'h88, 1'b0);
    n_cmp++; if (out_data !== 64'h88 || count !== CW'(1)) begin
      n_err++; $display("FAIL clr_discard: got data=%h count=%0d exp 88/1", out_data, count);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) push_word({$urandom, $urandom}, 1'b0);
    push_word(64'h5A, 1'b1);
    n_cmp++; if (count !== CW'(6) || ovf_seen !== 1'b1) begin
      n_err++; $display("FAIL rstm_setup: got count=%0d ovf_seen=%b exp 6/1", count, ovf_seen);
    end
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    n_cmp++; if (count !== '0 || out_valid !== 1'b0 || empty !== 1'b1) begin
      n_err++; $display("FAIL rstm_count: got count=%0d valid=%b empty=%b exp 0/0/1", count, out_valid, empty);
    end
    n_cmp++; if (ovf_seen !== 1'b0 || drop_err !== 1'b0) begin
      n_err++; $display("FAIL rstm_flags: got ovf_seen=%b drop=%b exp 0/0", ovf_seen, drop_err);
    end
    n_cmp++; if (out_data !== '0 || out_addr !== '0) begin
      n_err++; $display("FAIL rstm_out: got data=%h addr=%h exp 0/0", out_data, out_addr);
    end
    exp_q.delete();
    exp_addr = '0;
    #2;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      in_valid    = 1'($urandom_range(0, 3) != 0);
      in_data     = {$urandom, $urandom};
      in_overflow = 1'($urandom_range(0, 7) == 0);
      out_ready   = 1'($urandom_range(0, 1));
      tick();
      n_cmp++;
      if (count !== CW'(exp_q.size())) begin
        n_err++; $display("FAIL b2b_count: got %0d exp %0d", count, exp_q.size());
      end
    end
    in_valid = 1'b0;
    drain();
  endtask

  initial begin
    n_rst = 1'b0; clear = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_data = '0; in_overflow = 1'b0; out_ready = 1'b0;
    exp_addr = '0;
    #12;
    test_reset();
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_in_order();
    test_addr_wrap();
    test_full_drop();
    test_overflow();
    test_clear_priority();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
